// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_DIV   = 3'd6,
        OP_DIVU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Signed variants treat operands as two's complement.
    function automatic logic is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

    // Accumulating variants combine the product with the forwarded {hi, lo}.
    function automatic logic is_acc(input muldiv_op_t op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    // Subtracting accumulate: hilo - product.
    function automatic logic is_sub(input muldiv_op_t op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is high during the last iteration cycle; quotient/remainder then show
// the final values so the caller can register them on the same edge.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   shifted, trial;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration registers: load on start, step while the counter is non-zero.
    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(WIDTH);
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

    assign done      = (cnt_q == CNT_W'(1));
    assign quotient  = quo_n;
    assign remainder = rem_n;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / divide engine for the EX stage.
// One start/done handshake; result_o is {hi, lo}.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int CNT_W = 3;

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op_in, op_q, mop;
    logic [WIDTH-1:0]   opa_q, opb_q, ma, mb;
    logic [2*WIDTH-1:0] hilo_q, mh, a_ext, b_ext, prod, mul_res;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;
    logic               accept, in_zero, msgn;

    logic               core_start, core_done, sa, sb, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   core_quo, core_rem, quo_fix, rem_fix;

    assign op_in   = muldiv_op_t'(op_i);
    assign accept  = (state_q == ST_IDLE) && start_i && !flush_i;
    assign in_zero = is_div(op_in) && (opb_i == '0);

    // Multiplier: live inputs when a 1-cycle multiply completes straight from
    // IDLE, captured operands otherwise. Truncation to 2*WIDTH gives the wrap.
    always_comb begin
        mop = op_q;
        ma  = opa_q;
        mb  = opb_q;
        mh  = hilo_q;
        if (state_q == ST_IDLE) begin
            mop = op_in;
            ma  = opa_i;
            mb  = opb_i;
            mh  = hilo_i;
        end
        msgn  = is_signed(mop);
        a_ext = {{WIDTH{msgn & ma[WIDTH-1]}}, ma};
        b_ext = {{WIDTH{msgn & mb[WIDTH-1]}}, mb};
        prod  = a_ext * b_ext;
        if (is_acc(mop)) begin
            mul_res = is_sub(mop) ? (mh - prod) : (mh + prod);
        end else begin
            mul_res = prod;
        end
    end

    // Divider runs on magnitudes; signs are re-applied from the captured operands.
    assign in_neg_a   = is_signed(op_in) & opa_i[WIDTH-1];
    assign in_neg_b   = is_signed(op_in) & opb_i[WIDTH-1];
    assign core_start = accept && is_div(op_in) && !in_zero;
    assign sa         = is_signed(op_q) & opa_q[WIDTH-1];
    assign sb         = is_signed(op_q) & opb_q[WIDTH-1];
    assign quo_fix    = (sa ^ sb) ? -core_quo : core_quo;
    assign rem_fix    = sa ? -core_rem : core_rem;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (in_neg_a ? -opa_i : opa_i),
        .divisor   (in_neg_b ? -opb_i : opb_i),
        .cancel    (flush_i),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // updates from pre-edge values regardless of block order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush in any busy state abandons the op without done.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_div(op_in))      state_d = in_zero ? ST_DONE : ST_DIV;
                    else if (MUL_LAT == 1)  state_d = ST_DONE;
                    else                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (flush_i)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(1))     state_d = ST_DONE;
            end
            ST_DIV: begin
                if (flush_i)        state_d = ST_IDLE;
                else if (core_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, multiply latency counter and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand registers are reset as well; keeps X out of the
            // datapath after reset at negligible cost for this handful of flops.
            op_q     <= OP_MULT;
            opa_q    <= '0;
            opb_q    <= '0;
            hilo_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= op_in;
                opa_q  <= opa_i;
                opb_q  <= opb_i;
                hilo_q <= hilo_i;
                cnt_q  <= CNT_W'(MUL_LAT - 1);
                dbz_q  <= in_zero;
            end else if (state_q == ST_MUL) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_d == ST_DONE) begin
                unique case (state_q)
                    ST_DIV:  result_q <= {rem_fix, quo_fix};
                    ST_IDLE: result_q <= in_zero ? {opa_i, {WIDTH{1'b1}}} : mul_res;
                    default: result_q <= mul_res;
                endcase
            end
        end
    end

    assign busy_o        = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o        = (state_q == ST_DONE);
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: vector table, randomized ops against an arithmetic model,
// and hand-written sequences for flush, reset, busy-start and back-to-back cases.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit, MUL_LAT=2 instance
    logic        start, flush, busy, done, dbz;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [63:0] hilo, result;

    // 16-bit, MUL_LAT=1 instance
    logic        s_start, s_flush, s_busy, s_done, s_dbz;
    logic [2:0]  s_op;
    logic [15:0] s_opa, s_opb;
    logic [31:0] s_hilo, s_result;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) u32 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
        .hilo_i(hilo), .flush_i(flush), .busy_o(busy), .done_o(done),
        .result_o(result), .div_by_zero_o(dbz)
    );

    muldiv_unit #(.WIDTH(16), .MUL_LAT(1)) u16 (
        .clk(clk), .rst(rst), .start_i(s_start), .op_i(s_op), .opa_i(s_opa), .opb_i(s_opb),
        .hilo_i(s_hilo), .flush_i(s_flush), .busy_o(s_busy), .done_o(s_done),
        .result_o(s_result), .div_by_zero_o(s_dbz)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic straight from the op definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] h, output logic [63:0] res,
                                  output logic z, output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = 64'(a);
        ub = 64'(b);
        z   = 1'b0;
        lat = 2;
        res = '0;
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: res = h + sa * sb;
            3'd3: res = h + ua * ub;
            3'd4: res = h - sa * sb;
            3'd5: res = h - ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                    z   = 1'b1;
                    lat = 1;
                end else begin
                    lat = 33;
                    if (o == 3'd6) begin
                        q = sa / sb;
                        r = sa % sb;
                        res = {r[31:0], q[31:0]};
                    end else begin
                        uq = ua / ub;
                        ur = ua % ub;
                        res = {ur[31:0], uq[31:0]};
                    end
                end
            end
        endcase
    endfunction

    // Issue one op on the 32-bit unit, scramble inputs afterwards, wait for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, output logic [63:0] r, output logic z,
                          output int lat, output logic busy1, output logic done_after);
        @(negedge clk);
        op = o; opa = a; opb = b; hilo = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); opa = $urandom; opb = $urandom; hilo = {$urandom, $urandom};
        lat   = 1;
        busy1 = busy;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        r = result;
        z = dbz;
        @(negedge clk);
        done_after = done;
    endtask

    // Count done pulses over n cycles on the 32-bit unit.
    task automatic watch_done(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            if (done) seen++;
            @(negedge clk);
        end
    endtask

    // Issue one op on the 16-bit unit and wait for done.
    task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] h, output logic [31:0] r, output int lat);
        @(negedge clk);
        s_op = o; s_opa = a; s_opb = b; s_hilo = h; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; s_opa = 16'($urandom); s_opb = 16'($urandom);
        lat = 1;
        while (!s_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!s_done) lat = -1;
        r = s_result;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[13];
        logic [63:0] r, prior;
        logic [31:0] r16;
        logic        z, b1, da, ez;
        logic [63:0] er;
        int          lat, el, seen, k;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         64'd0,                   64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 2};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         64'd0,                   64'h0000_0002_FFFF_FFFA, 1'b0, 2};
        vecs[2]  = '{3'd2, 32'd4,         32'd5,         64'h10,                  64'h0000_0000_0000_0024, 1'b0, 2};
        vecs[3]  = '{3'd4, 32'd4,         32'd5,         64'h10,                  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 2};
        vecs[4]  = '{3'd3, 32'd1,         32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b0, 2};
        vecs[5]  = '{3'd5, 32'd1,         32'd1,         64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         64'd0,                   64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
        vecs[7]  = '{3'd7, 32'h8000_0000, 32'h10,        64'd0,                   64'h0000_0000_0800_0000, 1'b0, 33};
        vecs[8]  = '{3'd7, 32'h1234,      32'd0,         64'd0,                   64'h0000_1234_FFFF_FFFF, 1'b1, 1};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,                   64'h0000_0000_8000_0000, 1'b0, 33};
        vecs[10] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 64'd0,                   64'h0000_0001_FFFF_FFFD, 1'b0, 33};
        vecs[11] = '{3'd7, 32'd5,         32'd7,         64'd0,                   64'h0000_0005_0000_0000, 1'b0, 33};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'd0,         64'd0,                   64'h8000_0000_FFFF_FFFF, 1'b1, 1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0; hilo = '0;
        s_start = 1'b0; s_flush = 1'b0; s_op = '0; s_opa = '0; s_opb = '0; s_hilo = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   busy,   1'b0);
        check("reset_done",   done,   1'b0);
        check("reset_result", result, 64'd0);
        check("reset_dbz",    dbz,    1'b0);
        check("reset16_result", {s_busy, s_done, s_dbz, s_result}, '0);
        rst = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo, r, z, lat, b1, da);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_dbz", i), z, vecs[i].dbz);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_after_start", i), b1, vecs[i].lat > 1);
            check($sformatf("vec%0d_done_one_pulse", i), da, 1'b0);
        end

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 15))
                0, 1: rb = 32'd0;
                2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3, 4: rb = 32'($urandom_range(1, 255));
                default: ;
            endcase
            model(ro, ra, rb, {$urandom, $urandom}, er, ez, el);
            // re-derive with the same hilo that is applied
            begin
                logic [63:0] h;
                h = {$urandom, $urandom};
                model(ro, ra, rb, h, er, ez, el);
                run_op(ro, ra, rb, h, r, z, lat, b1, da);
            end
            check($sformatf("rnd%0d_op%0d_result", i, ro), r, er);
            check($sformatf("rnd%0d_op%0d_dbz", i, ro), z, ez);
            check($sformatf("rnd%0d_op%0d_latency", i, ro), lat, el);
        end

        // Flush mid-divide: no done, result untouched, unit usable afterwards
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, prior, z, lat, b1, da);
        check("flush_prior_result", prior, 64'hFFFF_FFFF_FFFF_FFFA);
        @(negedge clk);
        op = 3'd6; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_low", busy, 1'b0);
        watch_done(40, seen);
        check("flush_no_done", seen, 0);
        check("flush_result_kept", result, prior);
        run_op(3'd0, 32'd3, 32'd3, 64'd0, r, z, lat, b1, da);
        check("after_flush_mult", r, 64'd9);

        // Flush in the last divide cycle wins over completion
        @(negedge clk);
        op = 3'd7; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("late_flush_no_done", done, 1'b0);
        check("late_flush_busy", busy, 1'b0);
        check("late_flush_result_kept", result, 64'd9);

        // start_i while busy is ignored
        @(negedge clk);
        op = 3'd6; opa = 32'hFFFF_FFF9; opb = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd0; opa = 32'd1; opb = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 6;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy_start_latency", k, 33);
        check("busy_start_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        check("busy_start_not_queued", busy, 1'b0);

        // start_i in the DONE cycle is ignored
        @(negedge clk);
        op = 3'd0; opa = 32'd2; opb = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_first_done", done, 1'b1);
        op = 3'd1; opa = 32'd5; opb = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_start_ignored", busy, 1'b0);
        watch_done(6, seen);
        check("b2b_no_second_done", seen, 0);
        check("b2b_result", result, 64'd4);

        // flush and start together in IDLE: start dropped
        @(negedge clk);
        op = 3'd0; opa = 32'd7; opb = 32'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_dropped", busy, 1'b0);
        watch_done(5, seen);
        check("flush_start_no_done", seen, 0);

        // div_by_zero_o holds in IDLE until the next accepted start
        run_op(3'd7, 32'd9, 32'd0, 64'd0, r, z, lat, b1, da);
        repeat (2) @(negedge clk);
        check("dbz_hold", dbz, 1'b1);
        op = 3'd0; opa = 32'd2; opb = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dbz_clear", dbz, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a multiply
        @(negedge clk);
        op = 3'd0; opa = 32'hFFFF_FFFE; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_done", done, 1'b0);
        watch_done(5, seen);
        check("rst_mid_no_done", seen, 0);

        // 16-bit, single-cycle multiply instance
        run16(3'd0, 16'hFFFE, 16'd3, 32'd0, r16, lat);
        check("w16_mult_result", r16, 32'hFFFF_FFFA);
        check("w16_mult_latency", lat, 1);
        run16(3'd3, 16'hFFFF, 16'hFFFF, 32'h0001_0000, r16, lat);
        check("w16_maddu_result", r16, 32'hFFFF_0001);
        run16(3'd6, 16'hFFF9, 16'd2, 32'd0, r16, lat);
        check("w16_div_result", r16, 32'hFFFF_FFFD);
        check("w16_div_latency", lat, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
